// File: rtl/p_hardisc.sv
// Shared definitions for the iterative multiply/divide unit: RV32M funct3
// encodings, the MDU state enum and the operand-signedness classes.
package p_hardisc;

  localparam logic [2:0] MDU_F_MUL    = 3'b000;
  localparam logic [2:0] MDU_F_MULH   = 3'b001;
  localparam logic [2:0] MDU_F_MULHSU = 3'b010;
  localparam logic [2:0] MDU_F_MULHU  = 3'b011;
  localparam logic [2:0] MDU_F_DIV    = 3'b100;
  localparam logic [2:0] MDU_F_DIVU   = 3'b101;
  localparam logic [2:0] MDU_F_REM    = 3'b110;
  localparam logic [2:0] MDU_F_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state;

  typedef enum logic [2:0] {
    CLS_MUL_UU, CLS_MUL_SS, CLS_MUL_SU, CLS_DIV_S, CLS_DIV_U
  } mdu_class;

  // Ops in one class produce the same 2*XLEN result, so they can share a cache entry.
  function automatic mdu_class mdu_class_of(input logic [2:0] funct);
    if (funct[2]) return funct[0] ? CLS_DIV_U : CLS_DIV_S;
    if (funct == MDU_F_MULH) return CLS_MUL_SS;
    if (funct == MDU_F_MULHSU) return CLS_MUL_SU;
    return CLS_MUL_UU;
  endfunction

  function automatic logic mdu_takes_low(input logic [2:0] funct);
    return (funct == MDU_F_MUL) || (funct == MDU_F_DIV) || (funct == MDU_F_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// DIV_BPC cascaded restoring-division steps on unsigned magnitudes.
module mdu_div_step #(
  parameter int XLEN    = 32,
  parameter int DIV_BPC = 1
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quot_next
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // The dividend is shifted out of the quotient register into the remainder;
  // a non-negative trial difference sets the new quotient bit.
  always_comb begin
    rem_next  = rem;
    quot_next = quot;
    trial     = '0;
    diff      = '0;
    for (int i = 0; i < DIV_BPC; i++) begin
      trial     = {rem_next, quot_next[XLEN-1]};
      diff      = trial - {1'b0, divisor};
      quot_next = {quot_next[XLEN-2:0], ~diff[XLEN]};
      rem_next  = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit with early completion on special
// divide cases, last-result reuse and abort on flush or withdrawal.
module mdu_iter
  import p_hardisc::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 4,
  parameter int DIV_BPC = 1
) (
  input  logic            s_clk_i,
  input  logic            s_resetn_i,
  input  logic            s_flush_i,
  input  logic            s_stall_i,
  input  logic            s_start_i,
  input  logic [2:0]      s_function_i,
  input  logic [XLEN-1:0] s_operand1_i,
  input  logic [XLEN-1:0] s_operand2_i,
  output logic            s_finished_o,
  output logic [XLEN-1:0] s_result_o,
  output logic            s_busy_o
);

  localparam int PW        = 2 * XLEN;
  localparam int CW        = $clog2(XLEN) + 1;
  localparam int MUL_ITERS = XLEN / MUL_BPC;
  localparam int DIV_ITERS = XLEN / DIV_BPC;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state        state_q, state_d;
  logic [2:0]      func_q;
  logic [XLEN-1:0] op1_q, op2_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   acc_q, mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic            mplier_neg_q;
  logic [XLEN-1:0] rem_q, quot_q, divisor_q;
  logic            quot_neg_q, rem_neg_q;
  logic [XLEN-1:0] result_q;
  logic            cache_valid_q;
  mdu_class        cache_class_q;
  logic [XLEN-1:0] cache_op1_q, cache_op2_q;
  logic [PW-1:0]   cache_data_q;

  logic            start_ok, req_sdiv, op1_neg, op2_neg, a_signed, b_signed;
  logic            div_zero, div_ovf, special, cache_hit, last_iter;
  logic [PW-1:0]   fast_data, pp, acc_next, calc_data;
  logic [XLEN-1:0] rem_step, quot_step, quot_fin, rem_fin;

  function automatic logic [XLEN-1:0] pick_half(input logic [2:0] f, input logic [PW-1:0] d);
    return mdu_takes_low(f) ? d[XLEN-1:0] : d[PW-1:XLEN];
  endfunction

  assign start_ok  = s_start_i & ~s_flush_i;
  assign req_sdiv  = s_function_i[2] & ~s_function_i[0];
  assign op1_neg   = s_operand1_i[XLEN-1];
  assign op2_neg   = s_operand2_i[XLEN-1];
  assign a_signed  = (s_function_i == MDU_F_MULH) || (s_function_i == MDU_F_MULHSU);
  assign b_signed  = (s_function_i == MDU_F_MULH);
  assign div_zero  = s_function_i[2] & (s_operand2_i == '0);
  assign div_ovf   = req_sdiv & (s_operand1_i == INT_MIN) & (s_operand2_i == '1);
  assign special   = div_zero | div_ovf;
  assign cache_hit = cache_valid_q & (cache_class_q == mdu_class_of(s_function_i))
                   & (cache_op1_q == s_operand1_i) & (cache_op2_q == s_operand2_i);
  // Both fast paths are packed as {high/remainder, low/quotient}.
  assign fast_data = div_zero ? {s_operand1_i, {XLEN{1'b1}}}
                   : div_ovf  ? {{XLEN{1'b0}}, s_operand1_i}
                   : cache_data_q;
  assign last_iter = cnt_q == (func_q[2] ? CW'(DIV_ITERS - 1) : CW'(MUL_ITERS - 1));

  // Shift-add partial product; the multiplier's sign weight is -2^XLEN, so it
  // is subtracted once the multiplicand has reached that alignment.
  always_comb begin
    pp = '0;
    for (int j = 0; j < MUL_BPC; j++)
      if (mplier_q[j]) pp = pp + (mcand_q << j);
    if (last_iter && mplier_neg_q) pp = pp - (mcand_q << MUL_BPC);
    acc_next = acc_q + pp;
  end

  mdu_div_step #(.XLEN(XLEN), .DIV_BPC(DIV_BPC)) u_div_step (
    .rem       (rem_q),
    .quot      (quot_q),
    .divisor   (divisor_q),
    .rem_next  (rem_step),
    .quot_next (quot_step)
  );

  assign quot_fin  = quot_neg_q ? -quot_step : quot_step;
  assign rem_fin   = rem_neg_q ? -rem_step : rem_step;
  assign calc_data = func_q[2] ? {rem_fin, quot_fin} : acc_next;

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = (special || cache_hit) ? DONE : CALC;
      CALC: begin
        if (s_flush_i || !s_start_i) state_d = IDLE;
        else if (last_iter)          state_d = DONE;
      end
      DONE:    if (s_flush_i || !s_start_i || !s_stall_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_finished_o = (state_q == DONE);
    s_busy_o     = (state_q != IDLE);
    s_result_o   = result_q;
  end

  // Datapath and reuse cache; both multiply and divide registers are loaded
  // on every capture since only the ones matching the function are consumed.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      func_q        <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      mplier_neg_q  <= 1'b0;
      rem_q         <= '0;
      quot_q        <= '0;
      divisor_q     <= '0;
      quot_neg_q    <= 1'b0;
      rem_neg_q     <= 1'b0;
      result_q      <= '0;
      cache_valid_q <= 1'b0;
      cache_class_q <= CLS_MUL_UU;
      cache_op1_q   <= '0;
      cache_op2_q   <= '0;
      cache_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_ok) begin
          func_q       <= s_function_i;
          op1_q        <= s_operand1_i;
          op2_q        <= s_operand2_i;
          cnt_q        <= '0;
          acc_q        <= '0;
          mcand_q      <= {{XLEN{a_signed & op1_neg}}, s_operand1_i};
          mplier_q     <= s_operand2_i;
          mplier_neg_q <= b_signed & op2_neg;
          rem_q        <= '0;
          quot_q       <= (req_sdiv && op1_neg) ? -s_operand1_i : s_operand1_i;
          divisor_q    <= (req_sdiv && op2_neg) ? -s_operand2_i : s_operand2_i;
          quot_neg_q   <= req_sdiv & (op1_neg ^ op2_neg);
          rem_neg_q    <= req_sdiv & op1_neg;
          if (special || cache_hit) result_q <= pick_half(s_function_i, fast_data);
        end
        CALC: begin
          if (s_flush_i || !s_start_i) begin
            cache_valid_q <= 1'b0;
          end else begin
            cnt_q    <= cnt_q + 1'b1;
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << MUL_BPC;
            mplier_q <= mplier_q >> MUL_BPC;
            rem_q    <= rem_step;
            quot_q   <= quot_step;
            if (last_iter) begin
              result_q      <= pick_half(func_q, calc_data);
              cache_valid_q <= 1'b1;
              cache_class_q <= mdu_class_of(func_q);
              cache_op1_q   <= op1_q;
              cache_op2_q   <= op2_q;
              cache_data_q  <= calc_data;
            end
          end
        end
        DONE: if (!s_flush_i && !s_start_i) cache_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed RV32M cases plus random ops
// compared against a plain-arithmetic reference with a last-result cache model.
module tb_mdu_iter;

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n, flush, stall, start;
  logic [2:0]  func;
  logic [31:0] op1, op2;
  logic        finished, busy;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  // Model of the reuse cache: last fully computed op
  bit          m_valid = 1'b0;
  int          m_cls;
  logic [31:0] m_a, m_b;

  mdu_iter #(.XLEN(32), .MUL_BPC(4), .DIV_BPC(1)) dut (
    .s_clk_i      (clk),
    .s_resetn_i   (rst_n),
    .s_flush_i    (flush),
    .s_stall_i    (stall),
    .s_start_i    (start),
    .s_function_i (func),
    .s_operand1_i (op1),
    .s_operand2_i (op2),
    .s_finished_o (finished),
    .s_result_o   (result),
    .s_busy_o     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    bit ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      F_MUL:    begin p = ua * ub; return p[31:0];  end
      F_MULH:   begin p = sa * sb; return p[63:32]; end
      F_MULHSU: begin p = sa * ub; return p[63:32]; end
      F_MULHU:  begin p = ua * ub; return p[63:32]; end
      F_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      F_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int cls_of(input logic [2:0] f);
    if (f[2]) return f[0] ? 4 : 3;
    if (f == F_MULH) return 1;
    if (f == F_MULHSU) return 2;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, time its latency, optionally hold it in DONE with a stall,
  // then let it advance and confirm the unit returns to idle.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input int stall_cycles, input string tag);
    logic [31:0] exp_res;
    bit special, hit;
    int exp_lat, cyc;
    exp_res = ref_mdu(f, a, b);
    special = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    hit     = m_valid && (m_cls == cls_of(f)) && (m_a == a) && (m_b == b);
    exp_lat = (special || hit) ? 1 : (f[2] ? 33 : 9);
    @(negedge clk);
    start = 1'b1; func = f; op1 = a; op2 = b; stall = (stall_cycles > 0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!finished && cyc < 100);
    checkOutput({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    checkOutput({tag, "_res"}, result, exp_res);
    if (!special && !hit) begin
      m_valid = 1'b1; m_cls = cls_of(f); m_a = a; m_b = b;
    end
    repeat (stall_cycles) begin
      @(negedge clk);
      checkOutput({tag, "_hold_fin"}, {31'b0, finished}, 32'd1);
      checkOutput({tag, "_hold_res"}, result, exp_res);
    end
    stall = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_idle"}, {31'b0, busy}, 32'd0);
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b, pa, pb;
    logic [2:0]  f;
    int sel;
    rst_n = 1'b1; flush = 1'b0; stall = 1'b0; start = 1'b0;
    func = '0; op1 = '0; op2 = '0;
    #2 rst_n = 1'b0;
    #20;
    checkOutput("rst_fin", {31'b0, finished}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_res", result, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    applyStimulus(F_MUL, 32'd7, 32'hFFFF_FFFD, 0, "mul_7xm3");
    applyStimulus(F_DIV, 32'd100, 32'd7, 0, "div_100_7");
    applyStimulus(F_REM, 32'd100, 32'd7, 0, "rem_hit");
    applyStimulus(F_DIVU, 32'h0000_1234, 32'd0, 0, "divu_zero");
    applyStimulus(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    applyStimulus(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    applyStimulus(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_m1");
    applyStimulus(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_m1");
    applyStimulus(F_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_hit");
    applyStimulus(F_MULH, 32'h8000_0000, 32'h8000_0000, 0, "mulh_min");

    // Flush on the fifth CALC cycle aborts and drops the cached DIVU result
    applyStimulus(F_DIVU, 32'd50, 32'd5, 0, "divu_50_5");
    @(negedge clk);
    start = 1'b1; func = F_DIV; op1 = 32'd1000; op2 = 32'd3;
    repeat (5) @(negedge clk);
    checkOutput("flush_pre_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_busy", {31'b0, busy}, 32'd0);
    checkOutput("flush_fin", {31'b0, finished}, 32'd0);
    flush = 1'b0; start = 1'b0; m_valid = 1'b0;
    applyStimulus(F_REMU, 32'd50, 32'd5, 0, "remu_after_flush");
    applyStimulus(F_DIV, 32'd1000, 32'd3, 0, "div_reissue");

    // Withdrawing start in CALC also drops the cache
    applyStimulus(F_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 0, "mulhu_pre_wd");
    @(negedge clk);
    start = 1'b1; func = F_DIV; op1 = 32'd9; op2 = 32'd2;
    repeat (3) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("withdraw_busy", {31'b0, busy}, 32'd0);
    m_valid = 1'b0;
    applyStimulus(F_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 0, "mulhu_post_wd");

    applyStimulus(F_MULH, 32'hDEAD_BEEF, 32'h0BAD_F00D, 3, "mulh_stall");

    pa = 32'd77; pb = 32'd5;
    for (int i = 0; i < 24; i++) begin
      f   = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      if (sel == 0)      begin a = $urandom; b = 32'd0; end
      else if (sel == 1) begin a = pa; b = pb; end
      else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 3) begin a = $urandom; b = 32'($urandom_range(1, 15)); end
      else               begin a = $urandom; b = $urandom; end
      applyStimulus(f, a, b, 0, $sformatf("rand%0d", i));
      pa = a; pb = b;
    end

    // Asynchronous reset mid-calculation clears outputs without a clock edge
    @(negedge clk);
    start = 1'b1; func = F_MULHU; op1 = 32'hFFFF_FFFF; op2 = 32'h0000_0003;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_fin", {31'b0, finished}, 32'd0);
    checkOutput("arst_busy", {31'b0, busy}, 32'd0);
    checkOutput("arst_res", result, 32'd0);
    start = 1'b0; m_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    applyStimulus(F_REM, 32'hFFFF_FF9C, 32'd7, 0, "rem_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
